// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional forwarding support is selected by the FWD_EN macro in pipe_hazard_ctrl.
package pipe_ctrl_pkg;

  localparam int RA_W   = 5;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b11
  } state_t;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  // One bundle of pipeline-register controls, in the order the stages appear.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

endpackage

// File: rtl/hazard_cmp.sv
// Read-after-write comparator: flags a source register that matches a pending write.
module hazard_cmp #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            used,
  input  logic [RA_W-1:0] rd,
  input  logic            wr_en,
  output logic            hit
);

  // x0 is hardwired to zero, so it never carries a dependency.
  assign hit = used & wr_en & (rs != '0) & (rd == rs);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage pipeline, with memory-wait timeout.
// Define FWD_EN to build with EX-stage operand forwarding; otherwise RAW hazards stall.
module pipe_hazard_ctrl #(
  parameter int RA_W        = pipe_ctrl_pkg::RA_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  ID_RS1,
  input  logic [RA_W-1:0]  ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [RA_W-1:0]  EX_RS1,
  input  logic [RA_W-1:0]  EX_RS2,
  input  logic [RA_W-1:0]  EX_ARD,
  input  logic             EX_REGWRITE,
  input  logic             EX_MEMTOREG,
  input  logic             EX_BRANCH_TAKEN,
  input  logic [RA_W-1:0]  MEM_ARD,
  input  logic             MEM_REGWRITE,
  input  logic             MEM_MEMWRITE,
  input  logic             MEM_MEMTOREG,
  input  logic             DMEM_READY,
  input  logic [RA_W-1:0]  WB_ARD,
  input  logic             WB_REGWRITE,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             MEM_WB_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             DMEM_ERR,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT
);

  import pipe_ctrl_pkg::*;

  localparam logic [WAIT_W:0]   TIMEOUT_L = (WAIT_W+1)'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [WAIT_W:0]   wait_inc;
  logic              mem_busy;
  logic              stall_hz;
  logic              ex_hit1, ex_hit2;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  ctrl_t             ctrl;

  assign mem_busy = (MEM_MEMWRITE | MEM_MEMTOREG) & ~DMEM_READY;
  assign wait_inc = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};

  hazard_cmp #(.RA_W(RA_W)) u_ex_rs1 (
    .rs(ID_RS1), .used(ID_USES_RS1), .rd(EX_ARD), .wr_en(EX_REGWRITE), .hit(ex_hit1)
  );
  hazard_cmp #(.RA_W(RA_W)) u_ex_rs2 (
    .rs(ID_RS2), .used(ID_USES_RS2), .rd(EX_ARD), .wr_en(EX_REGWRITE), .hit(ex_hit2)
  );

`ifdef FWD_EN
  logic mem_fa, mem_fb, wb_fa, wb_fb;

  hazard_cmp #(.RA_W(RA_W)) u_fwd_mem_a (
    .rs(EX_RS1), .used(1'b1), .rd(MEM_ARD), .wr_en(MEM_REGWRITE), .hit(mem_fa)
  );
  hazard_cmp #(.RA_W(RA_W)) u_fwd_mem_b (
    .rs(EX_RS2), .used(1'b1), .rd(MEM_ARD), .wr_en(MEM_REGWRITE), .hit(mem_fb)
  );
  hazard_cmp #(.RA_W(RA_W)) u_fwd_wb_a (
    .rs(EX_RS1), .used(1'b1), .rd(WB_ARD), .wr_en(WB_REGWRITE), .hit(wb_fa)
  );
  hazard_cmp #(.RA_W(RA_W)) u_fwd_wb_b (
    .rs(EX_RS2), .used(1'b1), .rd(WB_ARD), .wr_en(WB_REGWRITE), .hit(wb_fb)
  );

  // With forwarding, only a load result is too late to bypass into EX.
  assign stall_hz  = (ex_hit1 | ex_hit2) & EX_MEMTOREG;
  assign fwd_a_sel = mem_fa ? FWD_MEM : (wb_fa ? FWD_WB : FWD_REGFILE);
  assign fwd_b_sel = mem_fb ? FWD_MEM : (wb_fb ? FWD_WB : FWD_REGFILE);
`else
  logic mem_hit1, mem_hit2;
  logic unused_fwd_inputs;

  hazard_cmp #(.RA_W(RA_W)) u_mem_rs1 (
    .rs(ID_RS1), .used(ID_USES_RS1), .rd(MEM_ARD), .wr_en(MEM_REGWRITE), .hit(mem_hit1)
  );
  hazard_cmp #(.RA_W(RA_W)) u_mem_rs2 (
    .rs(ID_RS2), .used(ID_USES_RS2), .rd(MEM_ARD), .wr_en(MEM_REGWRITE), .hit(mem_hit2)
  );

  // WB is safe because the register file writes in the first half of the cycle.
  assign stall_hz          = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
  assign fwd_a_sel         = FWD_REGFILE;
  assign fwd_b_sel         = FWD_REGFILE;
  assign unused_fwd_inputs = ^{EX_RS1, EX_RS2, WB_ARD, WB_REGWRITE, EX_MEMTOREG};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // ERR is entered at the edge that ends the MEM_TIMEOUT-th consecutive busy cycle.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          if (MEM_TIMEOUT <= 1) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_MEM_WAIT;
            wait_nxt  = WAIT_ONE;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_inc >= TIMEOUT_L) begin
            state_nxt = ST_ERR;
          end else begin
            wait_nxt = wait_inc[WAIT_W-1:0];
          end
        end else begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_RUN;
    endcase
  end

  // A busy memory freezes everything upstream, so branches and hazards wait their turn.
  always_comb begin
    ctrl = '0;
    if (state == ST_ERR) begin
      ctrl = '0;
    end else if (mem_busy) begin
      ctrl.mem_wb_en    = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (EX_BRANCH_TAKEN) begin
      ctrl             = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    end else if (stall_hz) begin
      ctrl             = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    end else begin
      ctrl             = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    end
  end

  always_comb begin
    {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
     IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH} = rst ? '0 : ctrl;
    FWD_A = rst ? FWD_REGFILE : fwd_a_sel;
    FWD_B = rst ? FWD_REGFILE : fwd_b_sel;
  end

  assign STATE = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DMEM_ERR <= 1'b0;
    end else if (state_nxt == ST_ERR) begin
      DMEM_ERR <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      STALL_CNT <= '0;
    end else if (!ctrl.pc_en && (STALL_CNT != {CNT_W{1'b1}})) begin
      STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; expectations follow FWD_EN when it is defined.
module tb_pipe_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 16;
`ifdef FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  localparam logic [7:0] E_RUN   = 8'b11111_000;
  localparam logic [7:0] E_STALL = 8'b00111_010;
  localparam logic [7:0] E_BR    = 8'b11111_110;
  localparam logic [7:0] E_FRZ   = 8'b00001_001;
  localparam logic [7:0] E_OFF   = 8'b00000_000;

  typedef struct packed {
    logic            rst;
    logic [RA_W-1:0] id_rs1, id_rs2;
    logic            id_u1, id_u2;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_ard;
    logic            ex_rw, ex_m2r, br;
    logic [RA_W-1:0] mem_ard;
    logic            mem_rw, mem_mw, mem_m2r, rdy;
    logic [RA_W-1:0] wb_ard;
    logic            wb_rw;
  } in_t;

  typedef struct packed {
    logic [7:0]       ef;
    logic [1:0]       fa, fb;
    logic             err;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
  } outs_t;

  typedef struct {
    string name;
    outs_t exp;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  logic [RA_W-1:0] ID_RS1, ID_RS2, EX_RS1, EX_RS2, EX_ARD, MEM_ARD, WB_ARD;
  logic ID_USES_RS1, ID_USES_RS2, EX_REGWRITE, EX_MEMTOREG, EX_BRANCH_TAKEN;
  logic MEM_REGWRITE, MEM_MEMWRITE, MEM_MEMTOREG, DMEM_READY, WB_REGWRITE;
  logic PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
  logic IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, DMEM_ERR;
  logic [1:0] FWD_A, FWD_B, STATE;
  logic [CNT_W-1:0] STALL_CNT;

  in_t   cur;
  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    sc_exp = 0;

  always #5 clk = ~clk;

  assign rst             = cur.rst;
  assign ID_RS1          = cur.id_rs1;
  assign ID_RS2          = cur.id_rs2;
  assign ID_USES_RS1     = cur.id_u1;
  assign ID_USES_RS2     = cur.id_u2;
  assign EX_RS1          = cur.ex_rs1;
  assign EX_RS2          = cur.ex_rs2;
  assign EX_ARD          = cur.ex_ard;
  assign EX_REGWRITE     = cur.ex_rw;
  assign EX_MEMTOREG     = cur.ex_m2r;
  assign EX_BRANCH_TAKEN = cur.br;
  assign MEM_ARD         = cur.mem_ard;
  assign MEM_REGWRITE    = cur.mem_rw;
  assign MEM_MEMWRITE    = cur.mem_mw;
  assign MEM_MEMTOREG    = cur.mem_m2r;
  assign DMEM_READY      = cur.rdy;
  assign WB_ARD          = cur.wb_ard;
  assign WB_REGWRITE     = cur.wb_rw;

  pipe_hazard_ctrl #(.RA_W(RA_W), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_ARD(EX_ARD),
    .EX_REGWRITE(EX_REGWRITE), .EX_MEMTOREG(EX_MEMTOREG), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
    .MEM_ARD(MEM_ARD), .MEM_REGWRITE(MEM_REGWRITE), .MEM_MEMWRITE(MEM_MEMWRITE),
    .MEM_MEMTOREG(MEM_MEMTOREG), .DMEM_READY(DMEM_READY),
    .WB_ARD(WB_ARD), .WB_REGWRITE(WB_REGWRITE),
    .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN), .EX_MEM_EN(EX_MEM_EN),
    .MEM_WB_EN(MEM_WB_EN), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .MEM_WB_FLUSH(MEM_WB_FLUSH), .FWD_A(FWD_A), .FWD_B(FWD_B),
    .DMEM_ERR(DMEM_ERR), .STATE(STATE), .STALL_CNT(STALL_CNT)
  );

  function automatic in_t idle();
    in_t v;
    v     = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs and queue the response it must produce.
  task automatic applyStimulus(input in_t v, input logic [7:0] ef, input logic [1:0] fa,
                               input logic [1:0] fb, input logic err, input logic [1:0] st,
                               input string name);
    item_t it;
    @(posedge clk);
    #1;
    cur = v;
    if (v.rst) sc_exp = 0;
    it.name = name;
    it.exp  = '{ef, fa, fb, err, st, CNT_W'(sc_exp)};
    sb_q.push_back(it);
    if (!v.rst && !ef[7] && sc_exp < 65535) sc_exp++;
  endtask

  task automatic checkOutput(input item_t it);
    outs_t act;
    act = '{{PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH,
             MEM_WB_FLUSH}, FWD_A, FWD_B, DMEM_ERR, STATE, STALL_CNT};
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got en/fl=%b fwd=%b/%b err=%b st=%b cnt=%0d, expected en/fl=%b fwd=%b/%b err=%b st=%b cnt=%0d",
               it.name, act.ef, act.fa, act.fb, act.err, act.st, act.cnt,
               it.exp.ef, it.exp.fa, it.exp.fb, it.exp.err, it.exp.st, it.exp.cnt);
    end
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        checkOutput(it);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_t v;
    cur     = idle();
    cur.rst = 1'b1;

    v = idle(); v.rst = 1'b1;
    applyStimulus(v, E_OFF, 2'b00, 2'b00, 1'b0, 2'b00, "reset");
    v = idle();
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "idle");

    v = idle(); v.ex_rw = 1; v.ex_m2r = 1; v.ex_ard = 5; v.id_rs1 = 5; v.id_u1 = 1;
    applyStimulus(v, E_STALL, 2'b00, 2'b00, 1'b0, 2'b00, "load_use");
    v = idle(); v.ex_rs1 = 5; v.mem_ard = 5; v.mem_rw = 1; v.mem_m2r = 1;
    applyStimulus(v, E_RUN, FWD_ON ? 2'b10 : 2'b00, 2'b00, 1'b0, 2'b00, "lu_next_fwd");
    v = idle(); v.id_rs1 = 5; v.id_u1 = 1; v.mem_rw = 1; v.mem_ard = 5;
    applyStimulus(v, FWD_ON ? E_RUN : E_STALL, 2'b00, 2'b00, 1'b0, 2'b00, "mem_raw");
    v = idle(); v.ex_rw = 1; v.ex_m2r = 1; v.ex_ard = 0; v.id_rs1 = 0; v.id_u1 = 1;
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "x0_no_hazard");
    v = idle(); v.ex_rw = 1; v.ex_m2r = 1; v.ex_ard = 6; v.id_rs2 = 6; v.id_u2 = 0;
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "rs2_unused");
    v.id_u2 = 1;
    applyStimulus(v, E_STALL, 2'b00, 2'b00, 1'b0, 2'b00, "load_use_rs2");
    v = idle(); v.ex_rw = 1; v.ex_ard = 9; v.id_rs2 = 9; v.id_u2 = 1;
    applyStimulus(v, FWD_ON ? E_RUN : E_STALL, 2'b00, 2'b00, 1'b0, 2'b00, "alu_raw");
    v = idle(); v.ex_rw = 1; v.ex_m2r = 1; v.ex_ard = 5; v.id_rs1 = 5; v.id_u1 = 1; v.br = 1;
    applyStimulus(v, E_BR, 2'b00, 2'b00, 1'b0, 2'b00, "lu_branch");

    v = idle(); v.mem_ard = 7; v.wb_ard = 7; v.mem_rw = 1; v.wb_rw = 1; v.ex_rs2 = 7;
    applyStimulus(v, E_RUN, 2'b00, FWD_ON ? 2'b10 : 2'b00, 1'b0, 2'b00, "fwd_mem_prio");
    v.ex_rs2 = 0;
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "fwd_x0");
    v = idle(); v.wb_rw = 1; v.wb_ard = 3; v.ex_rs1 = 3; v.id_rs1 = 3; v.id_u1 = 1;
    applyStimulus(v, E_RUN, FWD_ON ? 2'b01 : 2'b00, 2'b00, 1'b0, 2'b00, "fwd_wb");

    v = idle(); v.mem_mw = 1; v.rdy = 1;
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "ready_same_cycle");
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.mem_m2r = 1; v.rdy = 0; v.br = 1;
      v.ex_rw = 1; v.ex_m2r = 1; v.ex_ard = 4; v.id_rs1 = 4; v.id_u1 = 1;
      applyStimulus(v, E_FRZ, 2'b00, 2'b00, 1'b0, (i == 0) ? 2'b00 : 2'b01, "mem_wait");
    end
    v = idle(); v.mem_m2r = 1; v.rdy = 1;
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b01, "mem_done");
    v = idle();
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "back_to_run");

    for (int i = 0; i < 15; i++) begin
      v = idle(); v.mem_mw = 1; v.rdy = 0;
      applyStimulus(v, E_FRZ, 2'b00, 2'b00, 1'b0, (i == 0) ? 2'b00 : 2'b01, "timeout_wait");
    end
    applyStimulus(v, E_OFF, 2'b00, 2'b00, 1'b1, 2'b11, "timeout_err");
    v = idle();
    applyStimulus(v, E_OFF, 2'b00, 2'b00, 1'b1, 2'b11, "err_sticky");
    applyStimulus(v, E_OFF, 2'b00, 2'b00, 1'b1, 2'b11, "err_sticky2");

    v = idle(); v.rst = 1;
    applyStimulus(v, E_OFF, 2'b00, 2'b00, 1'b0, 2'b00, "reset_from_err");
    v = idle();
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "run_after_err");
    for (int i = 0; i < 5; i++) begin
      v = idle(); v.mem_mw = 1; v.rdy = 0;
      applyStimulus(v, E_FRZ, 2'b00, 2'b00, 1'b0, (i == 0) ? 2'b00 : 2'b01, "wait_to_five");
    end
    v.rst = 1;
    applyStimulus(v, E_OFF, 2'b00, 2'b00, 1'b0, 2'b00, "reset_mid_wait");
    v = idle();
    applyStimulus(v, E_RUN, 2'b00, 2'b00, 1'b0, 2'b00, "post_reset");

    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending items, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
